// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command slave.
//   - Opcode byte constants sent by the host MCU.
//   - Decoder FSM state encoding and register-target encoding.
//   - Known waveform code values.
//   - Helper that classifies register-write opcodes.
package spi_cmd_pkg;

    localparam logic [7:0] OP_TON   = 8'h91;
    localparam logic [7:0] OP_TOFF  = 8'h9E;
    localparam logic [7:0] OP_WAVE  = 8'h9C;
    localparam logic [7:0] OP_IP    = 8'h93;
    localparam logic [7:0] OP_START = 8'h06;
    localparam logic [7:0] OP_STOP  = 8'h07;
    localparam logic [7:0] OP_FB    = 8'hAB;

    localparam logic [15:0] WAVE_CODE_8000 = 16'h8000;
    localparam logic [15:0] WAVE_CODE_2001 = 16'h2001;
    localparam logic [15:0] WAVE_CODE_6001 = 16'h6001;

    typedef enum logic [1:0] {StIdle, StDataLo, StDataHi, StFbTx} state_e;
    typedef enum logic [1:0] {TgtTon, TgtToff, TgtWave, TgtIp} target_e;

    function automatic logic is_reg_op(input logic [7:0] op);
        return (op == OP_TON) || (op == OP_TOFF) || (op == OP_WAVE) || (op == OP_IP);
    endfunction

endpackage

// File: rtl/spi_cmd_slave_if.sv
// SPI pin bundle between the host MCU (master) and the command slave.
//   sclk, cs_n, mosi : driven by the master
//   miso             : driven by the slave
interface spi_cmd_slave_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte shifter running in the clk_in domain.
//   clk_in, sys_rst_n : system clock, asynchronous active-low reset
//   sclk, cs_n, mosi  : raw asynchronous SPI pins (2-FF synchronized here)
//   tx_load, tx_byte  : when tx_load is high, tx_byte is loaded on cs_n falling
//   rx_byte           : last complete received byte (MSB first)
//   byte_valid        : one-cycle pulse when the 8th bit has been received
//   miso              : registered serial output, MSB first
module spi_byte_shifter (
    input  logic       clk_in,
    input  logic       sys_rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       miso
);

    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       cs_prev;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic       sclk_rise;
    logic       cs_fall;

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign cs_fall   = ~cs_sync[1] & cs_prev;
    assign miso      = tx_sr[7];

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // cs_n idles high so reset must not look like a falling edge
            sclk_sync  <= 2'b00;
            cs_sync    <= 2'b11;
            mosi_sync  <= 2'b00;
            sclk_prev  <= 1'b0;
            cs_prev    <= 1'b1;
            bit_cnt    <= 3'd0;
            rx_sr      <= 7'd0;
            rx_byte    <= 8'd0;
            byte_valid <= 1'b0;
            tx_sr      <= 8'd0;
        end else begin
            sclk_sync  <= {sclk_sync[0], sclk};
            cs_sync    <= {cs_sync[0], cs_n};
            mosi_sync  <= {mosi_sync[0], mosi};
            sclk_prev  <= sclk_sync[1];
            cs_prev    <= cs_sync[1];
            byte_valid <= 1'b0;

            if (cs_fall) begin
                // A new window always restarts framing; partial bytes are lost here
                bit_cnt <= 3'd0;
                tx_sr   <= tx_load ? tx_byte : 8'd0;
            end else if (sclk_rise && !cs_sync[1]) begin
                rx_sr   <= {rx_sr[5:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                tx_sr   <= {tx_sr[6:0], 1'b0};
                if (bit_cnt == 3'd7) begin
                    rx_byte    <= {rx_sr, mosi_sync[1]};
                    byte_valid <= 1'b1;
                end
            end

            if (!tx_load) begin
                tx_sr <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI command slave: decodes opcode/data byte streams from the host MCU,
// commits 16-bit configuration registers atomically, issues start/stop
// pulses and serves a 4-byte feedback readback on miso.
//   clk_in, sys_rst_n : 50 MHz system clock, asynchronous active-low reset
//   spi               : SPI pins (slave modport)
//   fb_data           : feedback word, captured when opcode 0xAB is decoded
//   ton, toff         : pulse on/off times in us
//   waveform, ip_set  : waveform code, peak current in 0.5 A units
//   cfg_upd           : one-cycle pulse in the cycle a register changes
//   start_pulse       : one-cycle pulse on opcode 0x06
//   stop_pulse        : one-cycle pulse on opcode 0x07
// Build option: define SPI_CMD_TIMEOUT_EN to abort multi-byte sequences
// after TIMEOUT_CYC clk_in cycles without a completed byte.
module spi_cmd_slave
    import spi_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic                  clk_in,
    input  logic                  sys_rst_n,
    spi_cmd_slave_if.slave        spi,
    input  logic [31:0]           fb_data,
    output logic [15:0]           ton,
    output logic [15:0]           toff,
    output logic [15:0]           waveform,
    output logic [15:0]           ip_set,
    output logic                  cfg_upd,
    output logic                  start_pulse,
    output logic                  stop_pulse
);

    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        tx_load;
    logic [7:0]  tx_byte;
    logic        timeout_hit;
    state_e      state_q;
    state_e      cur_st;
    target_e     target_q;
    logic [7:0]  lo_q;
    logic [31:0] fb_shadow;
    logic [1:0]  fb_idx;

    spi_byte_shifter u_shifter (
        .clk_in     (clk_in),
        .sys_rst_n  (sys_rst_n),
        .sclk       (spi.sclk),
        .cs_n       (spi.cs_n),
        .mosi       (spi.mosi),
        .tx_load    (tx_load),
        .tx_byte    (tx_byte),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .miso       (spi.miso)
    );

    assign tx_load = (state_q == StFbTx);

    always_comb begin
        tx_byte = fb_shadow[7:0];
        unique case (fb_idx)
            2'd0: tx_byte = fb_shadow[7:0];
            2'd1: tx_byte = fb_shadow[15:8];
            2'd2: tx_byte = fb_shadow[23:16];
            2'd3: tx_byte = fb_shadow[31:24];
            default: tx_byte = fb_shadow[7:0];
        endcase
    end

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0] tmo_cnt;

    assign timeout_hit = (state_q != StIdle) && (tmo_cnt == TmoW'(TIMEOUT_CYC));

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt <= '0;
        end else if (state_q == StIdle || byte_valid) begin
            tmo_cnt <= '0;
        end else if (!timeout_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // No timeout: the FSM waits indefinitely; the parameter stays referenced
    assign timeout_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

    // A timeout in the same cycle as a byte takes effect first, so the byte
    // is decoded as if the FSM were already idle.
    always_comb begin
        cur_st = timeout_hit ? StIdle : state_q;
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            target_q    <= TgtTon;
            lo_q        <= 8'd0;
            fb_shadow   <= 32'd0;
            fb_idx      <= 2'd0;
            ton         <= 16'd0;
            toff        <= 16'd0;
            waveform    <= 16'd0;
            ip_set      <= 16'd0;
            cfg_upd     <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
        end else begin
            cfg_upd     <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            if (timeout_hit) begin
                state_q <= StIdle;
            end
            if (byte_valid) begin
                unique case (cur_st)
                    StIdle: begin
                        if (is_reg_op(rx_byte)) begin
                            state_q <= StDataLo;
                        end
                        case (rx_byte)
                            OP_TON:   target_q <= TgtTon;
                            OP_TOFF:  target_q <= TgtToff;
                            OP_WAVE:  target_q <= TgtWave;
                            OP_IP:    target_q <= TgtIp;
                            OP_START: start_pulse <= 1'b1;
                            OP_STOP:  stop_pulse  <= 1'b1;
                            OP_FB: begin
                                fb_shadow <= fb_data;
                                fb_idx    <= 2'd0;
                                state_q   <= StFbTx;
                            end
                            default: ;
                        endcase
                    end
                    StDataLo: begin
                        lo_q    <= rx_byte;
                        state_q <= StDataHi;
                    end
                    StDataHi: begin
                        // Both halves land in one cycle so no half-written value is visible
                        unique case (target_q)
                            TgtTon:  ton      <= {rx_byte, lo_q};
                            TgtToff: toff     <= {rx_byte, lo_q};
                            TgtWave: waveform <= {rx_byte, lo_q};
                            TgtIp:   ip_set   <= {rx_byte, lo_q};
                            default: ;
                        endcase
                        cfg_upd <= 1'b1;
                        state_q <= StIdle;
                    end
                    StFbTx: begin
                        fb_idx <= fb_idx + 2'd1;
                        if (fb_idx == 2'd3) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Self-checking bench for spi_cmd_slave: a bit-banged SPI master drives
// byte windows, a reference model of the registers pushes expected events
// into a scoreboard, and a monitor pops them as the DUT pulses.
module tb_spi_cmd_slave;
    import spi_cmd_pkg::*;

    localparam logic [7:0] EV_CFG   = 8'h01;
    localparam logic [7:0] EV_START = 8'h02;
    localparam logic [7:0] EV_STOP  = 8'h03;

    logic        clk_in = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] fb_data;
    logic [15:0] ton, toff, waveform, ip_set;
    logic        cfg_upd, start_pulse, stop_pulse;

    spi_cmd_slave_if spi ();

    spi_cmd_slave #(
        .TIMEOUT_CYC (5000)
    ) dut (
        .clk_in      (clk_in),
        .sys_rst_n   (sys_rst_n),
        .spi         (spi),
        .fb_data     (fb_data),
        .ton         (ton),
        .toff        (toff),
        .waveform    (waveform),
        .ip_set      (ip_set),
        .cfg_upd     (cfg_upd),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse)
    );

    always #10 clk_in = ~clk_in;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [71:0] exp_q[$];
    logic [7:0]  fb_q[$];
    logic [15:0] m_ton = 16'd0, m_toff = 16'd0, m_wave = 16'd0, m_ip = 16'd0;

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [71:0] got);
        if (exp_q.size() == 0) begin
            check_val({tag, "_unexpected"}, got, 72'd0);
        end else begin
            check_val(tag, got, exp_q.pop_front());
        end
    endtask

    always @(negedge clk_in) begin
        if (sys_rst_n) begin
            if (cfg_upd)     sb_pop("cfg",   {EV_CFG,   ton, toff, waveform, ip_set});
            if (start_pulse) sb_pop("start", {EV_START, ton, toff, waveform, ip_set});
            if (stop_pulse)  sb_pop("stop",  {EV_STOP,  ton, toff, waveform, ip_set});
        end
    end

    task automatic push_ev(input logic [7:0] kind);
        exp_q.push_back({kind, m_ton, m_toff, m_wave, m_ip});
    endtask

    // One cs_n window; shifts the top nbits of tx, captures miso on each rising edge
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        @(negedge clk_in);
        spi.cs_n = 1'b0;
        repeat (8) @(negedge clk_in);
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi.mosi = tx[i];
            repeat (4) @(negedge clk_in);
            rx[i] = spi.miso;
            spi.sclk = 1'b1;
            repeat (4) @(negedge clk_in);
            spi.sclk = 1'b0;
        end
        repeat (4) @(negedge clk_in);
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        repeat (10) @(negedge clk_in);
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] dummy;
        spi_xfer(b, 8, dummy);
    endtask

    task automatic wr_reg(input logic [7:0] op, input logic [15:0] val);
        case (op)
            OP_TON:  m_ton  = val;
            OP_TOFF: m_toff = val;
            OP_WAVE: m_wave = val;
            default: m_ip   = val;
        endcase
        push_ev(EV_CFG);
        send(op);
        send(val[7:0]);
        send(val[15:8]);
    endtask

    task automatic pulse_reset();
        @(negedge clk_in);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
    endtask

    initial begin
        logic [7:0] rx;
        logic [31:0] fb_word;
        spi.sclk = 1'b0;
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        fb_data  = 32'd0;
        repeat (5) @(negedge clk_in);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge clk_in);

        check_val("rst_ton",   72'(ton),         72'd0);
        check_val("rst_toff",  72'(toff),        72'd0);
        check_val("rst_wave",  72'(waveform),    72'd0);
        check_val("rst_ip",    72'(ip_set),      72'd0);
        check_val("rst_cfg",   72'(cfg_upd),     72'd0);
        check_val("rst_start", 72'(start_pulse), 72'd0);
        check_val("rst_stop",  72'(stop_pulse),  72'd0);
        check_val("rst_miso",  72'(spi.miso),    72'd0);

        // Register writes, little-endian data bytes
        wr_reg(OP_TON, 16'd100);
        wr_reg(OP_WAVE, 16'h6001);
        wr_reg(OP_IP, 16'd60);

        push_ev(EV_START);
        send(OP_START);
        push_ev(EV_STOP);
        send(OP_STOP);

        // Feedback readback; fb_data changes after capture to prove the shadow holds
        fb_word = 32'h1234ABCD;
        fb_data = fb_word;
        for (int i = 0; i < 4; i++) fb_q.push_back(fb_word[8*i +: 8]);
        send(OP_FB);
        fb_data = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            spi_xfer(8'hFF, 8, rx);
            check_val($sformatf("fb_byte%0d", i), 72'(rx), 72'(fb_q.pop_front()));
        end
        check_val("miso_idle", 72'(spi.miso), 72'd0);
        push_ev(EV_START);
        send(OP_START);

        // Partial third byte is discarded
        m_toff = 16'd50;
        push_ev(EV_CFG);
        send(OP_TOFF);
        send(8'h32);
        spi_xfer(8'hFF, 4, rx);
        send(8'h00);

        // Reset mid-sequence returns to idle with all registers cleared
        send(OP_TON);
        send(8'h22);
        pulse_reset();
        m_ton = 16'd0; m_toff = 16'd0; m_wave = 16'd0; m_ip = 16'd0;
        check_val("rst2_regs", 72'({ton, toff, waveform, ip_set}), 72'd0);
        push_ev(EV_START);
        send(OP_START);

        // Long stall inside a register write
        send(OP_TON);
        send(8'h10);
        repeat (6000) @(negedge clk_in);
`ifdef SPI_CMD_TIMEOUT_EN
        push_ev(EV_START);
`else
        m_ton = 16'h0610;
        push_ev(EV_CFG);
`endif
        send(OP_START);

        repeat (20) @(negedge clk_in);
        check_val("drain_events", 72'(exp_q.size()), 72'd0);
        check_val("drain_fb",     72'(fb_q.size()),  72'd0);
        check_val("final_regs", 72'({ton, toff, waveform, ip_set}),
                  72'({m_ton, m_toff, m_wave, m_ip}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
